// File: rtl/lfsr_color_seq.sv
// rtl/lfsr_color_seq.sv - Galois-LFSR colour sequence source with replayable seed
module lfsr_color_seq #(
    parameter int                    SEED_WIDTH = 16,
    parameter logic [SEED_WIDTH-1:0] TAPS       = 16'hB400,
    parameter logic [SEED_WIDTH-1:0] ZERO_SUB   = 16'hACE1,
    parameter int                    LEN_W      = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SEED_WIDTH-1:0] seed_in,
    input  logic                  seed_load,
    input  logic                  restart,
    input  logic [LEN_W-1:0]      seq_len,
    input  logic                  color_ready,
    output logic                  color_valid,
    output logic [1:0]            color_out,
    output logic [LEN_W-1:0]      color_idx,
    output logic                  seq_done,
    output logic                  seeded
);

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_PRESENT = 2'd1,
        S_STEP    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [SEED_WIDTH-1:0] seed_hold_q, seed_hold_d;
    logic [SEED_WIDTH-1:0] lfsr_q, lfsr_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      idx_q, idx_d;
    logic                  seeded_q, seeded_d;

    logic [SEED_WIDTH-1:0] load_seed;
    logic [LEN_W-1:0]      idx_next;
    state_t                start_state;

    // One right-shift Galois step; the feedback mask is folded in when the bit shifted out is 1.
    function automatic logic [SEED_WIDTH-1:0] galois_step(input logic [SEED_WIDTH-1:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : '0);
    endfunction

    // An all-zero seed would lock the LFSR at zero, so it is replaced by a fixed non-zero seed.
    assign load_seed   = (seed_in == '0) ? ZERO_SUB : seed_in;
    assign idx_next    = idx_q + LEN_W'(1);
    assign start_state = (seq_len == '0) ? S_DONE : S_PRESENT;

    // Next-state logic: seed_load beats restart, which beats an ordinary handshake.
    always_comb begin
        state_d     = state_q;
        seed_hold_d = seed_hold_q;
        lfsr_d      = lfsr_q;
        len_d       = len_q;
        idx_d       = idx_q;
        seeded_d    = seeded_q;

        if (seed_load) begin
            seed_hold_d = load_seed;
            lfsr_d      = load_seed;
            len_d       = seq_len;
            idx_d       = '0;
            seeded_d    = 1'b1;
            state_d     = start_state;
        end else if (restart && (state_q != S_EMPTY)) begin
            lfsr_d  = seed_hold_q;
            len_d   = seq_len;
            idx_d   = '0;
            state_d = start_state;
        end else begin
            case (state_q)
                S_PRESENT: begin
                    if (color_ready) begin
                        lfsr_d = galois_step(galois_step(lfsr_q));
                        if (idx_next == len_q) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_next;
                            state_d = S_STEP;
                        end
                    end
                end
                S_STEP:  state_d = S_PRESENT;
                default: state_d = state_q;
            endcase
        end
    end

    // State and datapath registers; reset clears everything including the seeded flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_EMPTY;
            seed_hold_q <= '0;
            lfsr_q      <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            seeded_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            seed_hold_q <= seed_hold_d;
            lfsr_q      <= lfsr_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            seeded_q    <= seeded_d;
        end
    end

    // Outputs decode registered state only, so no input reaches an output combinationally.
    assign color_valid = (state_q == S_PRESENT);
    assign color_out   = color_valid ? lfsr_q[1:0] : 2'b00;
    assign color_idx   = idx_q;
    assign seq_done    = (state_q == S_DONE);
    assign seeded      = seeded_q;

endmodule

// File: tb/tb_lfsr_color_seq.sv
// tb/tb_lfsr_color_seq.sv - scoreboard bench for lfsr_color_seq
module tb_lfsr_color_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] seed_in = '0;
    logic        seed_load = 1'b0;
    logic        restart = 1'b0;
    logic [5:0]  seq_len = '0;
    logic        color_ready = 1'b0;
    logic        color_valid;
    logic [1:0]  color_out;
    logic [5:0]  color_idx;
    logic        seq_done;
    logic        seeded;

    int total = 0;
    int bad = 0;

    logic [7:0]  exp_q[$];
    logic [15:0] hold_seed = '0;
    bit          loaded = 1'b0;
    bit          prev_hs = 1'b0;

    lfsr_color_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seed_in    (seed_in),
        .seed_load  (seed_load),
        .restart    (restart),
        .seq_len    (seq_len),
        .color_ready(color_ready),
        .color_valid(color_valid),
        .color_out  (color_out),
        .color_idx  (color_idx),
        .seq_done   (seq_done),
        .seeded     (seeded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: polynomial x^16+x^14+x^13+x^11+1 in right-shift Galois form.
    function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
        logic [15:0] r;
        r = s;
        for (int k = 0; k < 2; k++) begin
            if (r[0]) r = (r >> 1) ^ 16'hB400;
            else      r = r >> 1;
        end
        return r;
    endfunction

    task automatic push_model(input logic [15:0] s0, input int len);
        logic [15:0] s;
        s = (s0 == 16'h0) ? 16'hACE1 : s0;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({6'(i), s[1:0]});
            s = lfsr_adv(s);
        end
    endtask

    // Scoreboard monitor: pops one expected colour per handshake, checks bubbles and idle colour.
    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst_n) begin
            prev_hs = 1'b0;
        end else begin
            if (prev_hs) chk("bubble_after_handshake", color_valid, 0);
            if (!color_valid) chk("idle_colour_zero", color_out, 0);
            if (color_valid && color_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_colour: got %0d idx %0d want none", color_out, color_idx);
                end else begin
                    e = exp_q.pop_front();
                    chk("colour", color_out, e[1:0]);
                    chk("colour_idx", color_idx, e[7:2]);
                end
            end
            prev_hs = color_valid && color_ready;
        end
    end

    task automatic cmd(input bit is_load, input bit also_restart, input logic [15:0] s, input int len);
        bit effective;
        @(posedge clk); #1;
        color_ready = 1'b0;
        seq_len     = 6'(len);
        seed_in     = s;
        seed_load   = is_load;
        restart     = !is_load || also_restart;
        effective   = is_load || loaded;
        exp_q.delete();
        if (is_load) begin
            hold_seed = s;
            loaded    = 1'b1;
        end
        if (effective) push_model(hold_seed, len);
        @(posedge clk); #1;
        seed_load = 1'b0;
        restart   = 1'b0;
        if (effective) begin
            chk("start_valid", color_valid, (len > 0) ? 1 : 0);
            chk("start_done", seq_done, (len > 0) ? 0 : 1);
            chk("start_idx", color_idx, 0);
        end
    endtask

    task automatic run_pass(input int len, input int rdy_pct);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(posedge clk); #1;
            if (seq_done) begin
                done = 1'b1;
                break;
            end
            color_ready = ($urandom_range(0, 99) < rdy_pct);
        end
        chk("pass_done", done, 1);
        chk("pass_all_delivered", exp_q.size(), 0);
        if (len > 0) chk("done_idx_holds", color_idx, len - 1);
        color_ready = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("done_sticky", seq_done, 1);
            chk("done_no_valid", color_valid, 0);
        end
        color_ready = 1'b0;
    endtask

    task automatic wait_q_size(input int n);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (exp_q.size() == n) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_handshakes", ok, 1);
    endtask

    initial begin
        logic [1:0]  first_c;
        logic [15:0] rs;
        int          rl;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", color_valid, 0);
        chk("rst_out", color_out, 0);
        chk("rst_idx", color_idx, 0);
        chk("rst_done", seq_done, 0);
        chk("rst_seeded", seeded, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Restart in EMPTY is ignored
        cmd(1'b0, 1'b0, 16'h0, 3);
        repeat (3) begin
            @(posedge clk); #1;
            chk("empty_restart_valid", color_valid, 0);
            chk("empty_restart_done", seq_done, 0);
            chk("empty_restart_seeded", seeded, 0);
        end

        // Known seed, full-rate consumer
        cmd(1'b1, 1'b0, 16'hACE1, 3);
        chk("first_colour_ace1", color_out, 1);
        chk("seeded_after_load", seeded, 1);
        run_pass(3, 100);

        // Zero seed behaves as the substitute seed
        cmd(1'b1, 1'b0, 16'h0000, 3);
        chk("first_colour_zero_seed", color_out, 1);
        run_pass(3, 100);

        // Replay with one extra colour
        cmd(1'b0, 1'b0, 16'h0, 4);
        run_pass(4, 100);

        // Back-pressure: outputs stay put while color_ready is low
        cmd(1'b1, 1'b0, 16'h1234, 5);
        first_c = exp_q[0][1:0];
        repeat (10) begin
            @(posedge clk); #1;
            chk("hold_valid", color_valid, 1);
            chk("hold_colour", color_out, first_c);
            chk("hold_idx", color_idx, 0);
        end
        run_pass(5, 60);

        // seed_load and restart together mid-sequence: load wins
        cmd(1'b1, 1'b0, 16'h5A5A, 6);
        color_ready = 1'b1;
        wait_q_size(4);
        cmd(1'b1, 1'b1, 16'h0F0F, 4);
        run_pass(4, 100);
        cmd(1'b0, 1'b0, 16'h0, 3);
        run_pass(3, 70);

        // Asynchronous reset in the bubble cycle
        cmd(1'b1, 1'b0, 16'hBEEF, 4);
        color_ready = 1'b1;
        wait_q_size(3);
        chk("in_step_bubble", color_valid, 0);
        #1;
        rst_n = 1'b0;
        color_ready = 1'b0;
        #1;
        chk("async_rst_valid", color_valid, 0);
        chk("async_rst_out", color_out, 0);
        chk("async_rst_idx", color_idx, 0);
        chk("async_rst_done", seq_done, 0);
        chk("async_rst_seeded", seeded, 0);
        exp_q.delete();
        loaded = 1'b0;
        hold_seed = '0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        cmd(1'b0, 1'b0, 16'h0, 2);
        @(posedge clk); #1;
        chk("post_rst_restart_ignored", color_valid, 0);

        // Zero-length pass
        cmd(1'b1, 1'b0, 16'h4321, 0);
        run_pass(0, 100);

        // Randomised loads and replays
        for (int it = 0; it < 10; it++) begin
            rs = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            rl = $urandom_range(0, 20);
            if (loaded && ($urandom_range(0, 2) == 0)) cmd(1'b0, 1'b0, rs, rl);
            else                                      cmd(1'b1, 1'b0, rs, rl);
            run_pass(rl, $urandom_range(30, 100));
        end

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lfsr_color_seq.md
# lfsr_color_seq

Pseudo-random colour sequence source for the Genius game, fed directly by the seed generator's seed output. It holds a 16-bit seed, expands it through a Galois LFSR into a stream of 2-bit colour codes, and presents them one at a time over a valid/ready handshake. It can rewind to the stored seed so each round replays the identical prefix before extending it by one colour.

## Interface
- SEED_WIDTH, 16: width of seed and LFSR state.
- TAPS, 16'hB400: Galois feedback mask (x^16+x^14+x^13+x^11+1).
- ZERO_SUB, 16'hACE1: substitute seed used when the loaded seed is all-zero.
- LEN_W, 6: width of sequence length and colour index.

- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- seed_in  in  SEED_WIDTH  seed from the seed generator.
- seed_load  in  1  single-cycle pulse: store seed_in and start a new sequence.
- restart  in  1  single-cycle pulse: rewind to the stored seed and replay.
- seq_len  in  LEN_W  number of colours in this pass; sampled on seed_load/restart.
- color_ready  in  1  consumer accepts the presented colour.
- color_valid  out  1  color_out/color_idx are valid.
- color_out  out  2  colour code (0..3); 2'b00 whenever color_valid=0.
- color_idx  out  LEN_W  index of the presented colour, 0-based.
- seq_done  out  1  pass complete; all seq_len colours delivered.
- seeded  out  1  a seed has been loaded since reset.

## Operation
- Registers: seed_hold, lfsr, len_reg, idx, state.
- LFSR step (right-shift Galois): next = (lfsr>>1) ^ (lfsr[0] ? TAPS : 0). Each accepted colour advances lfsr by two steps in one cycle; color_out = lfsr[1:0].
- Zero seed: if seed_in==0 on seed_load, seed_hold and lfsr take ZERO_SUB; the LFSR never holds 0 after a load.
- States: EMPTY (reset; nothing loaded), PRESENT (color_valid=1), STEP (one bubble cycle after a handshake, color_valid=0), DONE (seq_done=1, color_valid=0).
- seed_load (any state): seed_hold<=seed/sub, lfsr<=same, len_reg<=seq_len, idx<=0, seeded<=1; next state PRESENT, or DONE if seq_len==0.
- restart (any state except EMPTY): lfsr<=seed_hold, len_reg<=seq_len, idx<=0; next PRESENT, or DONE if seq_len==0. Ignored in EMPTY.
- Handshake (PRESENT and color_ready): lfsr advances two steps; if idx+1==len_reg -> DONE (idx holds last value); else idx<=idx+1 -> STEP -> PRESENT.
- STEP -> PRESENT unconditionally on the next edge.
- color_ready outside PRESENT: ignored.
- Priority on the same edge: seed_load > restart > handshake.
- DONE persists until seed_load or restart.
- seeded stays 1 until reset.

## Timing
- Reset (async assert): state EMPTY, lfsr=0, seed_hold=0, len_reg=0, idx=0; color_valid=0, color_out=0, color_idx=0, seq_done=0, seeded=0. Synchronous deassert assumed from the reset synchroniser.
- seed_load/restart sampled at edge k: color_valid=1 with colour 0 from cycle k+1.
- Handshake at edge k: color_valid=0 in cycle k+1 (STEP), next colour valid in cycle k+2. Sustained throughput is 1 colour per 2 cycles.
- Last handshake at edge k: seq_done=1 from cycle k+1.
- All outputs are registered or decoded from registers only; no combinational path from inputs to outputs.
- Reset mid-sequence returns to EMPTY immediately. A new seed_load is required.

## Test plan
- Reset, then seed_load with seed_in=16'hACE1, seq_len=3, color_ready=1 -> colours 1, 0, 2 at idx 0, 1, 2, each valid for one cycle with a one-cycle bubble between; seq_done=1 the cycle after the third handshake.
- seed_load with seed_in=0 -> identical output to the 16'hACE1 case; seeded=1.
- After DONE, restart with seq_len=4 -> replays 1, 0, 2, then a 4th colour equal to the 0x1C4E two-step successor's low bits; same seed, no reload.
- Hold color_ready=0 for 10 cycles in PRESENT -> color_valid, color_out and color_idx stay stable and idx does not advance.
- Assert seed_load and restart on the same edge mid-sequence -> seed_load wins: new seed_hold, idx=0. Restart while in EMPTY -> no change, color_valid stays 0.
- Assert rst_n low during STEP -> all outputs 0 immediately. seq_len=0 on seed_load -> DONE the next cycle, with color_valid never asserted.
